// File: rtl/jtsdram_pkg.sv
// jtsdram_pkg: shared state encoding, default LFSR constants
// and a saturating adder for the SDRAM pattern sequencer.
package jtsdram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PROG  = 3'd1,
      ST_PWAIT = 3'd2,
      ST_READ  = 3'd3,
      ST_RWAIT = 3'd4,
      ST_DONE  = 3'd5,
      ST_TOUT  = 3'd6
   } state_t;

   localparam logic [15:0] TAPS_DEF = 16'hD295;
   localparam logic [15:0] SEED_DEF = 16'hAAAA;

   function automatic logic [15:0] sat_add(
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/jtsdram_pseq_if.sv
// jtsdram_pseq_if: sequencer <-> programmer/reader bundle.
// master is the sequencer side, slave the memory-test side.
interface jtsdram_pseq_if #(
   parameter int BANKS = 4,
   parameter int KW    = 5
);
   logic                  run;
   logic [BANKS*KW-1:0]   ba_key;
   logic [15:0]           data_ref;
   logic                  prog_start;
   logic                  prog_done;
   logic                  rd_start;
   logic [BANKS-1:0]      ba_done;
   logic [BANKS-1:0]      ba_err;
   logic [15:0]           pass_cnt;
   logic [15:0]           err_cnt;
   logic                  busy;
   logic                  finished;
   logic                  timeout;

   modport master (
      input  run, prog_done, ba_done, ba_err,
      output ba_key, data_ref, prog_start, rd_start,
      output pass_cnt, err_cnt, busy, finished, timeout
   );

   modport slave (
      output run, prog_done, ba_done, ba_err,
      input  ba_key, data_ref, prog_start, rd_start,
      input  pass_cnt, err_cnt, busy, finished, timeout
   );
endinterface

// File: rtl/jtsdram_lfsr.sv
// jtsdram_lfsr: right-shifting Fibonacci LFSR plus per-bank keys
// taken from the register rotated right by b*KW.
module jtsdram_lfsr import jtsdram_pkg::*; #(
   parameter int LW    = 16,
   parameter int KW    = 5,
   parameter int BANKS = 4,
   parameter logic [LW-1:0] TAPS = LW'(TAPS_DEF),
   parameter logic [LW-1:0] SEED = LW'(SEED_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                step,
   output logic [BANKS*KW-1:0] key
);

   logic [LW-1:0] lfsr_q;
   logic [LW-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (step)
         lfsr_d = {^(lfsr_q & TAPS), lfsr_q[LW-1:1]};
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= lfsr_d;

   // Rotating right by r and taking bit j is lfsr[(r+j) mod LW].
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      for (genvar j = 0; j < KW; j++) begin : g_bit
         assign key[b*KW+j] = lfsr_q[(b*KW+j) % LW];
      end
   end

endmodule

// File: rtl/jtsdram_pseq.sv
// jtsdram_pseq: program / read-back pass sequencer with per-bank
// completion latching, error and pass counting, and a watchdog.
module jtsdram_pseq import jtsdram_pkg::*; #(
   parameter int BANKS = 4,
   parameter int KW    = 5,
   parameter int LW    = 16,
   parameter logic [LW-1:0] TAPS = LW'(TAPS_DEF),
   parameter logic [15:0]   SEED = SEED_DEF,
   parameter int ITER  = 0,
   parameter int TOW   = 20
) (
   input  logic           clk,
   input  logic           rst,
   jtsdram_pseq_if.master bus
);

   state_t           state_q, state_d;
   logic             pstart_q, pstart_d;
   logic             rstart_q, rstart_d;
   logic             busy_q, busy_d;
   logic             fin_q, fin_d;
   logic             tout_q, tout_d;
   logic [15:0]      dref_q, dref_d;
   logic [15:0]      pass_q, pass_d;
   logic [15:0]      err_q, err_d;
   logic [BANKS-1:0] lat_q, lat_d;
   logic [TOW-1:0]   tcnt_q, tcnt_d;

   logic             step;
   logic [BANKS-1:0] hit;
   logic [15:0]      nerr;
   logic [15:0]      pass_inc;
   logic [TOW-1:0]   tcnt_inc;
   logic             to_hit;

   jtsdram_lfsr #(
      .LW    (LW),
      .KW    (KW),
      .BANKS (BANKS),
      .TAPS  (TAPS),
      .SEED  (LW'(SEED))
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .step (step),
      .key  (bus.ba_key)
   );

   // Only the first done of a bank in a pass can raise an error.
   assign hit      = bus.ba_done & bus.ba_err & ~lat_q;
   assign pass_inc = sat_add(pass_q, 16'd1);
   assign tcnt_inc = tcnt_q + TOW'(1);
   assign to_hit   = &tcnt_inc;

   always_comb begin
      nerr = '0;
      for (int b = 0; b < BANKS; b++)
         nerr = nerr + {15'd0, hit[b]};
   end

   always_comb begin
      state_d = state_q;
      dref_d  = dref_q;
      pass_d  = pass_q;
      err_d   = err_q;
      lat_d   = lat_q;
      tcnt_d  = tcnt_q;
      step    = 1'b0;
      if (!bus.run) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_PROG;
            ST_PROG: begin
               state_d = ST_PWAIT;
               tcnt_d  = '0;
            end
            ST_PWAIT: begin
               if (bus.prog_done) begin
                  state_d = ST_READ;
               end else begin
                  tcnt_d = tcnt_inc;
                  if (to_hit) state_d = ST_TOUT;
               end
            end
            ST_READ: begin
               state_d = ST_RWAIT;
               lat_d   = '0;
               tcnt_d  = '0;
            end
            ST_RWAIT: begin
               lat_d = lat_q | bus.ba_done;
               err_d = sat_add(err_q, nerr);
               if (&lat_d) begin
                  step    = 1'b1;
                  dref_d  = dref_q + 16'd1;
                  pass_d  = pass_inc;
                  state_d = ST_PROG;
                  if (ITER != 0 && pass_inc == 16'(ITER))
                     state_d = ST_DONE;
               end else begin
                  tcnt_d = tcnt_inc;
                  if (to_hit) state_d = ST_TOUT;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Outputs are decoded from the next state so they align with it.
   assign pstart_d = (state_d == ST_PROG);
   assign rstart_d = (state_d == ST_READ);
   assign fin_d    = (state_d == ST_DONE);
   assign tout_d   = (state_d == ST_TOUT);
   assign busy_d   = state_d inside
      {ST_PROG, ST_PWAIT, ST_READ, ST_RWAIT};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pstart_q <= 1'b0;
         rstart_q <= 1'b0;
         busy_q   <= 1'b0;
         fin_q    <= 1'b0;
         tout_q   <= 1'b0;
         dref_q   <= SEED;
         pass_q   <= '0;
         err_q    <= '0;
         lat_q    <= '0;
         tcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         pstart_q <= pstart_d;
         rstart_q <= rstart_d;
         busy_q   <= busy_d;
         fin_q    <= fin_d;
         tout_q   <= tout_d;
         dref_q   <= dref_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         lat_q    <= lat_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign bus.prog_start = pstart_q;
   assign bus.rd_start   = rstart_q;
   assign bus.busy       = busy_q;
   assign bus.finished   = fin_q;
   assign bus.timeout    = tout_q;
   assign bus.data_ref   = dref_q;
   assign bus.pass_cnt   = pass_q;
   assign bus.err_cnt    = err_q;

endmodule

// File: tb/tb_jtsdram_pseq.sv
// tb_jtsdram_pseq: default build checked every cycle against a pass
// model; a small BANKS=2/TOW=4/ITER=3 build checked with literals.
module tb_jtsdram_pseq;

   logic clk = 1'b0;
   logic rst0;
   logic rst1;

   always #5 clk = ~clk;

   jtsdram_pseq_if #(.BANKS(4), .KW(5)) b0();
   jtsdram_pseq_if #(.BANKS(2), .KW(3)) b1();

   jtsdram_pseq u0 (
      .clk (clk),
      .rst (rst0),
      .bus (b0)
   );

   jtsdram_pseq #(
      .BANKS (2),
      .KW    (3),
      .TOW   (4),
      .ITER  (3)
   ) u1 (
      .clk (clk),
      .rst (rst1),
      .bus (b1)
   );

   int passes = 0;
   int total  = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] l);
      int par;
      par = $countones(l & 16'hD295) % 2;
      return {par[0], l[15:1]};
   endfunction

   function automatic logic [31:0] keys(input logic [15:0] l,
                                        input int nb,
                                        input int kw);
      logic [31:0] r;
      logic [15:0] rot;
      int sh;
      r = '0;
      for (int b = 0; b < nb; b++) begin
         sh  = (b * kw) % 16;
         rot = (sh == 0) ? l : ((l >> sh) | (l << (16 - sh)));
         for (int j = 0; j < kw; j++) r[b*kw+j] = rot[j];
      end
      return r;
   endfunction

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   // Pass-level model of the default build.
   typedef enum {M_IDLE, M_PROG, M_PWAIT, M_READ,
                 M_RWAIT, M_DONE, M_TOUT} mst_t;
   localparam int M_TOLIM = (1 << 20) - 1;

   mst_t        ms     = M_IDLE;
   logic [15:0] m_lfsr = 16'hAAAA;
   logic [15:0] m_dref = 16'hAAAA;
   logic [15:0] m_pass = '0;
   logic [15:0] m_err  = '0;
   logic [3:0]  m_lat  = '0;
   int          m_cyc  = 0;
   int          m_entry = 0;

   always @(posedge clk or posedge rst0) begin
      if (rst0) begin
         ms <= M_IDLE;
         m_lfsr <= 16'hAAAA;
         m_dref <= 16'hAAAA;
         m_pass <= '0;
         m_err <= '0;
         m_lat <= '0;
         m_cyc <= 0;
         m_entry <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (!b0.run) ms <= M_IDLE;
         else case (ms)
            M_IDLE: ms <= M_PROG;
            M_PROG: begin
               ms <= M_PWAIT;
               m_entry <= m_cyc + 1;
            end
            M_PWAIT:
               if (b0.prog_done) ms <= M_READ;
               else if (m_cyc + 1 - m_entry >= M_TOLIM) ms <= M_TOUT;
            M_READ: begin
               ms <= M_RWAIT;
               m_lat <= '0;
               m_entry <= m_cyc + 1;
            end
            M_RWAIT: begin
               m_err <= sat16(int'(m_err) + $countones(
                  b0.ba_done & b0.ba_err & ~m_lat));
               m_lat <= m_lat | b0.ba_done;
               if ((m_lat | b0.ba_done) == 4'hF) begin
                  m_lfsr <= lstep(m_lfsr);
                  m_dref <= m_dref + 16'd1;
                  m_pass <= sat16(int'(m_pass) + 1);
                  ms <= M_PROG;
               end else if (m_cyc + 1 - m_entry >= M_TOLIM) begin
                  ms <= M_TOUT;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("m_prog_start", 32'(b0.prog_start), 32'(ms == M_PROG));
      chk("m_rd_start", 32'(b0.rd_start), 32'(ms == M_READ));
      chk("m_busy", 32'(b0.busy), 32'(ms inside
          {M_PROG, M_PWAIT, M_READ, M_RWAIT}));
      chk("m_finished", 32'(b0.finished), 32'(ms == M_DONE));
      chk("m_timeout", 32'(b0.timeout), 32'(ms == M_TOUT));
      chk("m_data_ref", 32'(b0.data_ref), 32'(m_dref));
      chk("m_pass_cnt", 32'(b0.pass_cnt), 32'(m_pass));
      chk("m_err_cnt", 32'(b0.err_cnt), 32'(m_err));
      chk("m_ba_key", 32'(b0.ba_key), keys(m_lfsr, 4, 5));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: return b0.prog_start;
         1: return b1.prog_start;
         default: return b1.rd_start;
      endcase
   endfunction

   task automatic wt(input string nm, input int sel, input int lim);
      int n = 0;
      while (!sig(sel) && n < lim) begin
         tick();
         n++;
      end
      chk(nm, 32'(sig(sel)), 32'd1);
   endtask

   task automatic prog0();
      wt("wait_prog0", 0, 20);
      repeat (3) tick();
      b0.prog_done = 1'b1;
      tick();
      b0.prog_done = 1'b0;
      chk("rd_start0", 32'(b0.rd_start), 32'd1);
      tick();
   endtask

   task automatic pass0(input logic [3:0] err, input int reps);
      prog0();
      b0.ba_done = 4'hF;
      b0.ba_err  = err;
      repeat (reps) tick();
      b0.ba_done = '0;
      b0.ba_err  = '0;
   endtask

   task automatic pass1();
      wt("wait_prog1", 1, 20);
      tick();
      b1.prog_done = 1'b1;
      tick();
      b1.prog_done = 1'b0;
      chk("rd_start1", 32'(b1.rd_start), 32'd1);
      tick();
      b1.ba_done = 2'b11;
      tick();
      b1.ba_done = '0;
   endtask

   task automatic reset0_lits(input string tag);
      chk({tag, "_prog_start"}, 32'(b0.prog_start), 32'd0);
      chk({tag, "_rd_start"}, 32'(b0.rd_start), 32'd0);
      chk({tag, "_busy"}, 32'(b0.busy), 32'd0);
      chk({tag, "_data_ref"}, 32'(b0.data_ref), 32'hAAAA);
      chk({tag, "_pass_cnt"}, 32'(b0.pass_cnt), 32'd0);
      chk({tag, "_err_cnt"}, 32'(b0.err_cnt), 32'd0);
      chk({tag, "_ba_key"}, 32'(b0.ba_key), 32'hAAAAA);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1);
   end

   logic [3:0] sched [1:11];
   int seen;

   initial begin
      rst0 = 1'b1;
      rst1 = 1'b1;
      b0.run = 1'b0; b0.prog_done = 1'b0;
      b0.ba_done = '0; b0.ba_err = '0;
      b1.run = 1'b0; b1.prog_done = 1'b0;
      b1.ba_done = '0; b1.ba_err = '0;
      for (int k = 1; k <= 11; k++) sched[k] = 4'h0;
      sched[2] = 4'b0010; sched[5] = 4'b0001;
      sched[9] = 4'b0110; sched[11] = 4'b1000;
      repeat (3) tick();
      reset0_lits("rst");
      rst0 = 1'b0;
      tick();
      b0.run = 1'b1;

      // First pass with simultaneous completion.
      pass0(4'h0, 1);
      chk("p1_data_ref", 32'(b0.data_ref), 32'hAAAB);
      chk("p1_pass_cnt", 32'(b0.pass_cnt), 32'd1);
      chk("p1_ba_key", 32'(b0.ba_key), 32'h5D555);

      // Staggered completion, bank1 twice, bank1 error.
      prog0();
      for (int k = 1; k <= 11; k++) begin
         b0.ba_done = sched[k];
         b0.ba_err  = 4'b0010;
         tick();
         if (k == 10)
            chk("stag_pre", 32'(b0.pass_cnt), 32'd1);
      end
      b0.ba_done = '0;
      b0.ba_err  = '0;
      chk("stag_done", 32'(b0.pass_cnt), 32'd2);
      chk("stag_err", 32'(b0.err_cnt), 32'd1);

      // Errors on banks 0 and 2, done repeated.
      pass0(4'b0101, 2);
      chk("err_cnt", 32'(b0.err_cnt), 32'd3);
      chk("p3_pass_cnt", 32'(b0.pass_cnt), 32'd3);

      // run drop holds the counters.
      b0.run = 1'b0;
      tick();
      chk("stop_busy", 32'(b0.busy), 32'd0);
      repeat (2) tick();
      chk("stop_dref", 32'(b0.data_ref), 32'hAAAD);
      b0.run = 1'b1;
      wt("resume0", 0, 4);
      chk("resume_dref", 32'(b0.data_ref), 32'hAAAD);

      // Asynchronous reset in the read wait.
      prog0();
      rst0 = 1'b1;
      #1;
      reset0_lits("async");
      tick();
      rst0 = 1'b0;
      chk("rel_prog_start", 32'(b0.prog_start), 32'd0);
      pass0(4'h0, 1);
      chk("rr_ba_key", 32'(b0.ba_key), 32'h5D555);
      chk("rr_data_ref", 32'(b0.data_ref), 32'hAAAB);
      b0.run = 1'b0;

      // Small build: keys, timeout, iteration limit.
      chk("b1_key", 32'(b1.ba_key), 32'h2A);
      chk("b1_key_rot", 32'(b1.ba_key), keys(16'hAAAA, 2, 3));
      rst1 = 1'b0;
      tick();
      b1.run = 1'b1;
      wt("b1_prog", 1, 4);
      tick();
      repeat (14) tick();
      chk("to_early", 32'(b1.timeout), 32'd0);
      tick();
      chk("to_hit", 32'(b1.timeout), 32'd1);
      chk("to_busy", 32'(b1.busy), 32'd0);
      repeat (3) tick();
      chk("to_sticky", 32'(b1.timeout), 32'd1);
      b1.run = 1'b0;
      tick();
      chk("to_clear", 32'(b1.timeout), 32'd0);
      b1.run = 1'b1;
      wt("to_resume", 1, 4);
      chk("to_dref", 32'(b1.data_ref), 32'hAAAA);
      pass1();
      chk("b1_key_p1", 32'(b1.ba_key), 32'h15);
      pass1();
      pass1();
      chk("it_finished", 32'(b1.finished), 32'd1);
      chk("it_pass_cnt", 32'(b1.pass_cnt), 32'd3);
      chk("it_dref", 32'(b1.data_ref), 32'hAAAD);
      seen = 0;
      repeat (20) begin
         tick();
         if (b1.prog_start) seen++;
      end
      chk("it_no_prog", 32'(seen), 32'd0);
      chk("it_sticky", 32'(b1.finished), 32'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/jtsdram_pseq.md
JTSDRAM_PSEQ -- requirements
Module: jtsdram_pseq

Interface
REQ-001 Parameter BANKS, default 4: number of read channels (1..8).
REQ-002 Parameter KW, default 5: key width per bank, in bits.
REQ-003 Parameter LW, default 16: LFSR width; LW >= KW required.
REQ-004 Parameter TAPS, default 16'hD295: LFSR feedback mask; bit i set means lfsr[i] is XORed into the feedback.
REQ-005 Parameter SEED, default 16'hAAAA: reset value of lfsr and data_ref.
REQ-006 Parameter ITER, default 0: number of passes; 0 means run forever.
REQ-007 Parameter TOW, default 20: timeout counter width.
REQ-008 Clock and reset: one clock; reset is asynchronous and active-high. Ports clk (input, 1, clock) and rst (input, 1, async active-high reset).
REQ-009 Port run, input, 1: enables sequencing; low forces return to IDLE.
REQ-010 Port ba_key, output, BANKS*KW: bank b key in bits [b*KW +: KW].
REQ-011 Port data_ref, output, 16: expected data word for the current pass.
REQ-012 Port prog_start, output, 1: one-cycle pulse that starts programming.
REQ-013 Port prog_done, input, 1: programming finished; level or pulse.
REQ-014 Port rd_start, output, 1: one-cycle pulse that starts all bank readers.
REQ-015 Port ba_done, input, BANKS: per-bank read finished; pulse or level.
REQ-016 Port ba_err, input, BANKS: per-bank mismatch flag, qualified by the same-cycle ba_done bit.
REQ-017 Port pass_cnt, output, 16: completed passes.
REQ-018 Port err_cnt, output, 16: bank-passes with error.
REQ-019 Port busy, output, 1: high when state is not IDLE, DONE or TOUT.
REQ-020 Port finished, output, 1: high in DONE.
REQ-021 Port timeout, output, 1: high in TOUT.

Function
REQ-022 States: IDLE, PROG, PWAIT, READ, RWAIT, DONE, TOUT.
REQ-023 IDLE with run=1 goes to PROG next cycle; PROG asserts prog_start for exactly one cycle and goes to PWAIT.
REQ-024 PWAIT with prog_done=1 goes to READ; READ asserts rd_start for exactly one cycle, clears done_lat[BANKS-1:0], and goes to RWAIT.
REQ-025 RWAIT sets done_lat[b] whenever ba_done[b]=1; banks may finish in any order or cycle.
REQ-026 When (done_lat | ba_done) is all ones, RWAIT ends the pass: lfsr advances one step, data_ref increments by 1 (16-bit wrap), and pass_cnt increments (saturating at 16'hFFFF).
REQ-027 LFSR step: lfsr <= {^(lfsr & TAPS), lfsr[LW-1:1]}.
REQ-028 Key mapping: bank b key = bits [KW-1:0] of lfsr rotated right by (b*KW mod LW).
REQ-029 ba_key is combinational from lfsr and stays stable from rd_start until the pass ends.
REQ-030 Error counting: each cycle, err_cnt adds popcount(ba_done & ba_err & ~done_lat), saturating. Repeated done on an already-latched bank is ignored.
REQ-031 At pass end, if ITER != 0 and the new pass_cnt equals ITER, go to DONE; otherwise go to PROG.
REQ-032 Timeout counter clears on entry to PWAIT and RWAIT and increments each cycle while in either state.
REQ-033 Timeout counter reaching all ones (2^TOW-1) goes to TOUT; completion in that same cycle takes priority.
REQ-034 DONE and TOUT are sticky while run=1; run=0 returns to IDLE.
REQ-035 run=0 in any state goes to IDLE next cycle. No start pulse is issued, and counters, lfsr and data_ref are held.
REQ-036 run 0->1 from IDLE resumes with current lfsr, data_ref and counters; only rst restores SEED.
REQ-037 prog_done is ignored outside PWAIT; ba_done and ba_err are ignored outside RWAIT.

Reset
REQ-038 rst asserted: state=IDLE, prog_start=0, rd_start=0, lfsr=SEED[LW-1:0], data_ref=SEED[15:0], pass_cnt=0, err_cnt=0, done_lat=0, timeout counter=0.
REQ-039 rst mid-operation aborts immediately; no pulse is emitted on release until run has been sampled high in IDLE.

Structure
REQ-040 State encoding localparams and default TAPS/SEED constants live in a shared jtsdram_pkg.
REQ-041 The LFSR (step, seed, rotate-key extraction) is one sub-module, jtsdram_lfsr, parametrised by LW, KW, BANKS and TAPS.

Verification
REQ-042 Defaults, run=1, prog_done 3 cycles after prog_start, all ba_done together -> ba_key = {lfsr[4:0] rotations}. After the pass, data_ref=16'hAAAB and pass_cnt=1.
REQ-043 ba_done bits staggered over cycles 2, 5, 9, 11 with bank1 pulsed twice -> exactly one pass completes, on cycle 11.
REQ-044 ba_err=4'b0101 with ba_done=4'b1111 in one pass -> err_cnt=2; a repeat of that done in the same pass does not change err_cnt.
REQ-045 TOW=4, prog_done never asserted -> timeout=1 at 15 cycles after PWAIT entry. run=0 then run=1 -> new prog_start with data_ref unchanged.
REQ-046 ITER=3 -> finished=1 after 3 passes, pass_cnt=3, and no further prog_start while run=1.
REQ-047 rst pulsed in RWAIT -> all outputs at reset values in the same cycle and lfsr=16'hAAAA; BANKS=2, KW=3 builds and the keys match the rotation rule.
